disdat_i2c_master: RTL and testbench
====================================

# disdat_i2c_master

Write-only I2C bus initiator for the DISDAT/DISCLK display bus. It serialises a device address plus a stream of data bytes onto open-drain SCL/SDA lines with START/STOP framing, ACK checking and fixed-rate bit timing. It drives the u3090mg display controller in place of the slave microcontroller's bit-banged port pins, and serves as a bench stimulus for the display path. It runs entirely in the clk30 domain.

## Interface
Parameters:
- HALF_PERIOD, default 150: clk30 cycles per SCL half-period. 150 gives 100 kHz; minimum legal value is 2.

Ports:
- clk30 in 1: system clock.
- reset in 1: synchronous, active-high.
- start in 1: single-cycle request to begin a transaction; ignored while busy.
- dev_addr in 7: 7-bit target address, captured on accepted start.
- byte_valid in 1: data byte available.
- byte_data in 8: data byte, MSB sent first.
- byte_last in 1: qualifies byte_data as the final byte of the transaction.
- byte_ready out 1: byte consumed this cycle when byte_valid is also high.
- busy out 1: transaction in progress.
- done out 1: one-cycle pulse at transaction end.
- nack out 1: valid only while done=1; 1 = address or data byte not acknowledged.
- scl out 1: clock line, 1 = released/high.
- sda_out out 1: data line drive, 1 = released, 0 = pull low.
- sda_in in 1: wired-AND line level, external driver combined with sda_out.

## Operation
- All outputs are registered. Reset values: scl=1, sda_out=1, busy=0, done=0, nack=0, byte_ready=0.
- States:
  - IDLE: lines released. Accepted start goes to START_A, latches {dev_addr,1'b0} into the shift register and sets the address phase.
  - START_A: SCL=1, SDA=1.
  - START_B: SCL=1, SDA=0. This is the START condition.
  - BIT_LO: SCL=0, SDA=current bit, set on phase entry.
  - BIT_HI: SCL=1, SDA held. After bit 0 go to ACK_LO, otherwise return to BIT_LO with the next bit.
  - ACK_LO: SCL=0, SDA released.
  - ACK_HI: SCL=1, SDA released. sda_in is sampled on the last cycle of this phase.
  - FETCH: SCL=0, SDA=0. byte_ready=1 while waiting. Leaves when byte_valid=1 and byte_ready=1, loads byte_data and byte_last, then goes to BIT_LO.
  - STOP_A: SCL=0, SDA=0.
  - STOP_B: SCL=1, SDA=0.
  - STOP_C: SCL=1, SDA=1. This is the STOP condition; next state is IDLE.
- Each state except IDLE and FETCH lasts exactly HALF_PERIOD cycles, counted by a down-counter reloaded on every state entry.
- After ACK_HI:
  - sda_in=1 (NACK): record nack, go to STOP_A.
  - Address-phase ACK: go to FETCH. Every transaction carries at least one data byte.
  - Data ACK with the latched last flag set: go to STOP_A.
  - Otherwise: go to FETCH.
- Address NACK consumes no data bytes. Data-byte NACK ends the transaction; remaining bytes stay unconsumed at the source.
- FETCH stalls indefinitely with SCL low. This is legal I2C: the clock is stretched by the initiator.
- The initiator never reads SCL. No arbitration and no responder clock-stretching are supported.
- Reset mid-transaction: lines are released on the next cycle and no STOP is generated.

## Timing
- start accepted in cycle T: busy=1 and START_A begins at T+1.
- SDA falls while SCL is high, at T+1+HALF_PERIOD.
- SDA changes only during SCL-low phases, except for START and STOP.
- byte_ready is high only in FETCH. A FETCH with byte_valid already high costs exactly 1 cycle.
- Unstalled transaction with N data bytes: busy is high for (5 + 18*(N+1))*HALF_PERIOD + N cycles.
- done=1 and nack are presented in the first IDLE cycle, the same cycle busy falls.
- start asserted in that same cycle is accepted.

## Test plan
- HALF_PERIOD=4, responder ACKs everything. Stimulus: start with dev_addr=0x3C, bytes 0xA5 then 0x01 (last), both pre-valid. Required: SDA bit stream 0x78, 0xA5, 0x01 sampled at SCL rising edges; busy high for 238 cycles; done with nack=0; exactly 2 byte_ready handshakes.
- Responder NACKs the address 0x3C. Required: STOP follows the 9th SCL pulse; done with nack=1; zero byte_ready handshakes.
- 3-byte stream, responder NACKs byte 2. Required: STOP after byte 2; nack=1; byte 3 never consumed.
- byte_valid withheld for 50 cycles after the address ACK. Required: SCL and SDA held low throughout; byte_ready stays 1; transfer resumes within 1 cycle of valid; busy lengthened by exactly 50 cycles.
- Assert reset during bit 3 of a data byte. Required: scl=1, sda_out=1, busy=0 next cycle; no done pulse. A start issued afterwards runs a full correct transaction.
- Pulse start while busy, and pulse start coincident with done. Required: the first is ignored; the second begins a new START at the following cycle.

Source files
------------

// File: rtl/disdat_i2c_master.sv
// Write-only I2C initiator for the DISDAT/DISCLK display bus: address + data-byte
// stream with START/STOP framing, ACK checking and fixed half-period bit timing.
module disdat_i2c_master #(
   parameter int HALF_PERIOD = 150
) (
   input  logic       clk30,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] dev_addr,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic       byte_last,
   output logic       byte_ready,
   output logic       busy,
   output logic       done,
   output logic       nack,
   output logic       scl,
   output logic       sda_out,
   input  logic       sda_in
);

   localparam int CW = $clog2(HALF_PERIOD + 1);
   localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START_A, S_START_B, S_BIT_LO, S_BIT_HI, S_ACK_LO,
      S_ACK_HI, S_FETCH, S_STOP_A, S_STOP_B, S_STOP_C
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_shift;
   logic [2:0]    r_bit;
   logic          r_addr, r_last;
   logic          r_scl, r_sda, r_busy, r_done, r_nack, r_ready;
   logic          w_tick;

   assign w_tick     = (r_cnt == '0);
   assign scl        = r_scl;
   assign sda_out    = r_sda;
   assign busy       = r_busy;
   assign done       = r_done;
   assign nack       = r_nack;
   assign byte_ready = r_ready;

   always_ff @(posedge clk30) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= RELOAD;
         r_shift <= '0;
         r_bit   <= '0;
         r_addr  <= 1'b0;
         r_last  <= 1'b0;
         r_scl   <= 1'b1;
         r_sda   <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_nack  <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // Timed states leave on the tick, which also reloads for the next state;
         // the untimed IDLE/FETCH exits reload explicitly.
         r_cnt  <= w_tick ? RELOAD : r_cnt - 1'b1;
         case (r_state)
            S_IDLE: if (start) begin
               r_state <= S_START_A;
               r_cnt   <= RELOAD;
               r_busy  <= 1'b1;
               r_shift <= {dev_addr, 1'b0};
               r_addr  <= 1'b1;
               r_nack  <= 1'b0;
            end
            S_START_A: if (w_tick) begin
               r_state <= S_START_B;
               r_sda   <= 1'b0;
            end
            S_START_B: if (w_tick) begin
               r_state <= S_BIT_LO;
               r_scl   <= 1'b0;
               r_sda   <= r_shift[7];
               r_bit   <= 3'd7;
            end
            S_BIT_LO: if (w_tick) begin
               r_state <= S_BIT_HI;
               r_scl   <= 1'b1;
            end
            S_BIT_HI: if (w_tick) begin
               r_scl <= 1'b0;
               if (r_bit == 3'd0) begin
                  r_state <= S_ACK_LO;
                  r_sda   <= 1'b1;
               end else begin
                  r_state <= S_BIT_LO;
                  r_bit   <= r_bit - 1'b1;
                  r_shift <= {r_shift[6:0], 1'b0};
                  r_sda   <= r_shift[6];
               end
            end
            S_ACK_LO: if (w_tick) begin
               r_state <= S_ACK_HI;
               r_scl   <= 1'b1;
            end
            S_ACK_HI: if (w_tick) begin
               r_scl <= 1'b0;
               r_sda <= 1'b0;
               if (sda_in) begin
                  r_nack  <= 1'b1;
                  r_state <= S_STOP_A;
               end else if (r_addr || !r_last) begin
                  r_addr  <= 1'b0;
                  r_state <= S_FETCH;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= S_STOP_A;
               end
            end
            // Initiator-side clock stretch: SCL stays low until a byte arrives.
            S_FETCH: if (byte_valid && r_ready) begin
               r_ready <= 1'b0;
               r_shift <= byte_data;
               r_last  <= byte_last;
               r_sda   <= byte_data[7];
               r_bit   <= 3'd7;
               r_state <= S_BIT_LO;
               r_cnt   <= RELOAD;
            end
            S_STOP_A: if (w_tick) begin
               r_state <= S_STOP_B;
               r_scl   <= 1'b1;
            end
            S_STOP_B: if (w_tick) begin
               r_state <= S_STOP_C;
               r_sda   <= 1'b1;
            end
            S_STOP_C: if (w_tick) begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_disdat_i2c_master.sv
// Directed bench for disdat_i2c_master: bus monitor/responder decodes SCL/SDA,
// a byte source feeds the stream, and each scenario task checks its own results.
module tb_disdat_i2c_master;
   localparam int HP = 4;

   logic       clk30 = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [6:0] dev_addr = '0;
   logic       byte_valid, byte_last, byte_ready, busy, done, nack, scl, sda_out, sda_in;
   logic [7:0] byte_data;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // byte source
   logic [7:0] src_q [8];
   int         src_n   = 0;
   int         src_idx = 0;
   logic       src_en  = 1'b1;
   assign byte_valid = src_en && (src_idx < src_n);
   assign byte_data  = src_q[src_idx[2:0]];
   assign byte_last  = (src_idx == src_n - 1);

   // responder: ack_plan bit k = 1 acknowledges byte k (0 = address)
   logic       ack_active = 1'b0;
   logic [7:0] ack_plan   = 8'hFF;
   assign sda_in = sda_out & ~ack_active;

   always #5 clk30 = ~clk30;

   disdat_i2c_master #(.HALF_PERIOD(HP)) dut (
      .clk30(clk30), .reset(reset), .start(start), .dev_addr(dev_addr),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
      .byte_ready(byte_ready), .busy(busy), .done(done), .nack(nack),
      .scl(scl), .sda_out(sda_out), .sda_in(sda_in)
   );

   // bus monitor, sampling exactly what the DUT sees at each edge
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   int         rises = 0, byte_idx = 0, tot_rises = 0, stop_rises = 0;
   int         busy_cnt = 0, hs_cnt = 0, stop_cnt = 0, start_cond = 0, done_cnt = 0;
   logic [7:0] sh = '0;
   logic [7:0] cap [4];

   always @(posedge clk30) begin
      prev_scl <= scl;
      prev_sda <= sda_in;
      if (!reset && done) done_cnt <= done_cnt + 1;
      if (reset) begin
         rises <= 0; byte_idx <= 0; ack_active <= 1'b0;
      end else if (start && !busy) begin
         rises <= 0; byte_idx <= 0; tot_rises <= 0; busy_cnt <= 0; hs_cnt <= 0;
         src_idx <= 0; stop_cnt <= 0; start_cond <= 0; ack_active <= 1'b0;
         for (int i = 0; i < 4; i++) cap[i] <= '0;
      end else begin
         if (busy) busy_cnt <= busy_cnt + 1;
         if (byte_valid && byte_ready) begin
            hs_cnt  <= hs_cnt + 1;
            src_idx <= src_idx + 1;
         end
         if (scl && !prev_scl) begin
            tot_rises <= tot_rises + 1;
            rises     <= rises + 1;
            sh        <= {sh[6:0], sda_in};
            if (rises == 7 && byte_idx < 4) cap[byte_idx[1:0]] <= {sh[6:0], sda_in};
         end
         if (!scl && prev_scl) begin
            if (rises == 8) ack_active <= ack_plan[byte_idx[2:0]];
            else if (rises == 9) begin
               ack_active <= 1'b0; rises <= 0; byte_idx <= byte_idx + 1;
            end
         end
         if (scl && prev_scl && prev_sda && !sda_in) begin
            start_cond <= start_cond + 1; rises <= 0; byte_idx <= 0;
         end
         if (scl && prev_scl && !prev_sda && sda_in) begin
            stop_cnt <= stop_cnt + 1; stop_rises <= tot_rises;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk30);
   endtask

   task automatic kick(input logic [6:0] a);
      dev_addr = a; start = 1'b1;
      @(negedge clk30);
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (done) begin ok = 1'b1; break; end
         @(negedge clk30);
      end
   endtask

   task automatic test_reset;
      cyc(3);
      chk_cnt++; if ({scl, sda_out, busy, done, nack, byte_ready} !== 6'b110000)
         $display("FAIL reset_values: got %b want 110000", {scl, sda_out, busy, done, nack, byte_ready}); else pass_cnt++;
      reset = 1'b0;
      cyc(2);
      chk_cnt++; if ({scl, sda_out, busy} !== 3'b110)
         $display("FAIL idle_after_reset: got %b want 110", {scl, sda_out, busy}); else pass_cnt++;
   endtask

   task automatic test_basic;
      bit ok;
      src_q[0] = 8'hA5; src_q[1] = 8'h01; src_n = 2; src_en = 1'b1; ack_plan = 8'hFF;
      kick(7'h3C);
      chk_cnt++; if ({busy, scl, sda_out} !== 3'b111)
         $display("FAIL basic_start_a: got %b want 111", {busy, scl, sda_out}); else pass_cnt++;
      cyc(HP);
      chk_cnt++; if ({scl, sda_out} !== 2'b10)
         $display("FAIL basic_start_cond: got %b want 10", {scl, sda_out}); else pass_cnt++;
      wait_done(ok);
      chk_cnt++; if (!ok) $display("FAIL basic_done_timeout: got none want done"); else pass_cnt++;
      chk_cnt++; if (nack !== 1'b0) $display("FAIL basic_nack: got %b want 0", nack); else pass_cnt++;
      chk_cnt++; if (cap[0] !== 8'h78) $display("FAIL basic_addr_byte: got %h want 78", cap[0]); else pass_cnt++;
      chk_cnt++; if (cap[1] !== 8'hA5) $display("FAIL basic_byte1: got %h want a5", cap[1]); else pass_cnt++;
      chk_cnt++; if (cap[2] !== 8'h01) $display("FAIL basic_byte2: got %h want 01", cap[2]); else pass_cnt++;
      chk_cnt++; if (busy_cnt !== 238) $display("FAIL basic_busy_len: got %0d want 238", busy_cnt); else pass_cnt++;
      chk_cnt++; if (hs_cnt !== 2) $display("FAIL basic_handshakes: got %0d want 2", hs_cnt); else pass_cnt++;
      chk_cnt++; if (stop_cnt !== 1) $display("FAIL basic_stop: got %0d want 1", stop_cnt); else pass_cnt++;
      cyc(1);
      chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else pass_cnt++;
   endtask

   task automatic test_addr_nack;
      bit ok;
      src_q[0] = 8'h55; src_q[1] = 8'h66; src_n = 2; ack_plan = 8'hFE;
      cyc(3);
      kick(7'h3C);
      wait_done(ok);
      chk_cnt++; if (!ok) $display("FAIL anack_done_timeout: got none want done"); else pass_cnt++;
      chk_cnt++; if (nack !== 1'b1) $display("FAIL anack_nack: got %b want 1", nack); else pass_cnt++;
      chk_cnt++; if (hs_cnt !== 0) $display("FAIL anack_handshakes: got %0d want 0", hs_cnt); else pass_cnt++;
      chk_cnt++; if (stop_rises !== 10) $display("FAIL anack_pulses_before_stop: got %0d want 10", stop_rises); else pass_cnt++;
      chk_cnt++; if (busy_cnt !== 92) $display("FAIL anack_busy_len: got %0d want 92", busy_cnt); else pass_cnt++;
   endtask

   task automatic test_data_nack;
      bit ok;
      src_q[0] = 8'h11; src_q[1] = 8'h22; src_q[2] = 8'h33; src_n = 3; ack_plan = 8'b1111_1011;
      cyc(3);
      kick(7'h50);
      wait_done(ok);
      chk_cnt++; if (!ok) $display("FAIL dnack_done_timeout: got none want done"); else pass_cnt++;
      chk_cnt++; if (nack !== 1'b1) $display("FAIL dnack_nack: got %b want 1", nack); else pass_cnt++;
      chk_cnt++; if (cap[0] !== 8'hA0) $display("FAIL dnack_addr_byte: got %h want a0", cap[0]); else pass_cnt++;
      chk_cnt++; if (cap[2] !== 8'h22) $display("FAIL dnack_byte2: got %h want 22", cap[2]); else pass_cnt++;
      chk_cnt++; if (hs_cnt !== 2 || src_idx !== 2)
         $display("FAIL dnack_consumed: got %0d/%0d want 2/2", hs_cnt, src_idx); else pass_cnt++;
      chk_cnt++; if (stop_rises !== 28) $display("FAIL dnack_pulses_before_stop: got %0d want 28", stop_rises); else pass_cnt++;
      chk_cnt++; if (busy_cnt !== 238) $display("FAIL dnack_busy_len: got %0d want 238", busy_cnt); else pass_cnt++;
      ack_plan = 8'hFF;
   endtask

   task automatic test_stall;
      bit ok, held;
      src_q[0] = 8'h5A; src_n = 1; src_en = 1'b0;
      cyc(3);
      kick(7'h3C);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (byte_ready) begin ok = 1'b1; break; end
         @(negedge clk30);
      end
      chk_cnt++; if (!ok) $display("FAIL stall_ready_timeout: got none want byte_ready"); else pass_cnt++;
      held = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (!(scl === 1'b0 && sda_out === 1'b0 && byte_ready === 1'b1)) held = 1'b0;
         @(negedge clk30);
      end
      chk_cnt++; if (!held) $display("FAIL stall_hold: got lines/ready changed want scl=0 sda=0 ready=1"); else pass_cnt++;
      src_en = 1'b1;
      @(negedge clk30);
      chk_cnt++; if ({byte_ready, scl, sda_out} !== 3'b000)
         $display("FAIL stall_resume: got %b want 000", {byte_ready, scl, sda_out}); else pass_cnt++;
      wait_done(ok);
      chk_cnt++; if (!ok) $display("FAIL stall_done_timeout: got none want done"); else pass_cnt++;
      chk_cnt++; if (busy_cnt !== 215) $display("FAIL stall_busy_len: got %0d want 215", busy_cnt); else pass_cnt++;
      chk_cnt++; if (cap[1] !== 8'h5A || nack !== 1'b0)
         $display("FAIL stall_data: got %h/%b want 5a/0", cap[1], nack); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      bit ok, quiet;
      int d0;
      src_q[0] = 8'hC3; src_q[1] = 8'h3C; src_n = 2;
      cyc(3);
      kick(7'h3C);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (byte_idx == 1 && rises == 5) begin ok = 1'b1; break; end
         @(negedge clk30);
      end
      chk_cnt++; if (!ok) $display("FAIL rmid_bit3_timeout: got none want bit 3"); else pass_cnt++;
      reset = 1'b1;
      @(negedge clk30);
      chk_cnt++; if ({scl, sda_out, busy, done} !== 4'b1100)
         $display("FAIL rmid_release: got %b want 1100", {scl, sda_out, busy, done}); else pass_cnt++;
      d0 = done_cnt;
      reset = 1'b0;
      quiet = 1'b1;
      repeat (20) begin
         if (done !== 1'b0) quiet = 1'b0;
         @(negedge clk30);
      end
      chk_cnt++; if (!quiet || done_cnt !== d0)
         $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt - d0); else pass_cnt++;
      src_q[0] = 8'h42; src_n = 1;
      kick(7'h3C);
      wait_done(ok);
      chk_cnt++; if (!ok) $display("FAIL rmid_after_timeout: got none want done"); else pass_cnt++;
      chk_cnt++; if ({cap[0], cap[1]} !== 16'h7842 || nack !== 1'b0)
         $display("FAIL rmid_after_data: got %h%h/%b want 7842/0", cap[0], cap[1], nack); else pass_cnt++;
      chk_cnt++; if (busy_cnt !== 165) $display("FAIL rmid_after_busy_len: got %0d want 165", busy_cnt); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      bit ok;
      int d0;
      src_q[0] = 8'h99; src_n = 1;
      cyc(3);
      d0 = done_cnt;
      kick(7'h3C);
      cyc(30);
      kick(7'h7F);
      chk_cnt++; if (start_cond !== 1) $display("FAIL b2b_ignored_start: got %0d starts want 1", start_cond); else pass_cnt++;
      wait_done(ok);
      chk_cnt++; if (!ok) $display("FAIL b2b_first_timeout: got none want done"); else pass_cnt++;
      chk_cnt++; if (cap[0] !== 8'h78) $display("FAIL b2b_first_addr: got %h want 78", cap[0]); else pass_cnt++;
      kick(7'h11);
      chk_cnt++; if ({busy, scl, sda_out} !== 3'b111)
         $display("FAIL b2b_second_start_a: got %b want 111", {busy, scl, sda_out}); else pass_cnt++;
      cyc(HP);
      chk_cnt++; if ({scl, sda_out} !== 2'b10)
         $display("FAIL b2b_second_start_cond: got %b want 10", {scl, sda_out}); else pass_cnt++;
      wait_done(ok);
      chk_cnt++; if (!ok) $display("FAIL b2b_second_timeout: got none want done"); else pass_cnt++;
      chk_cnt++; if ({cap[0], cap[1]} !== 16'h2299 || nack !== 1'b0)
         $display("FAIL b2b_second_data: got %h%h/%b want 2299/0", cap[0], cap[1], nack); else pass_cnt++;
      chk_cnt++; if (busy_cnt !== 165) $display("FAIL b2b_second_busy_len: got %0d want 165", busy_cnt); else pass_cnt++;
      cyc(2);
      chk_cnt++; if (done_cnt - d0 !== 2) $display("FAIL b2b_done_pulses: got %0d want 2", done_cnt - d0); else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) src_q[i] = '0;
      @(negedge clk30);
      test_reset();
      test_basic();
      test_addr_nack();
      test_data_nack();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
